// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential shift-and-add multiplier.
// Loads two DATAWIDTH-bit operands on an active-low start request, adds one
// partial product per clock for DATAWIDTH clocks, then presents the
// 2*DATAWIDTH-bit product together with a one-cycle done pulse and an
// active-low write strobe for the downstream result register.
// Optional build macro MULT_SIGNED_EN: operands are treated as two's complement.
// Their magnitudes are multiplied, and the sign is applied on completion.
module shift_add_multiplier #(
    parameter int DATAWIDTH = 8
) (
    input  logic                     clk,
    input  logic                     lowRst,
    input  logic                     lowStart,
    input  logic [DATAWIDTH-1:0]     A,
    input  logic [DATAWIDTH-1:0]     B,
    output logic [2*DATAWIDTH-1:0]   Product,
    output logic                     busy,
    output logic                     done,
    output logic                     lowWrOut
);

    localparam int PW = 2 * DATAWIDTH;
    localparam int CW = $clog2(DATAWIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [PW-1:0]   mcand;
    logic [PW-1:0]   acc;
    logic [DATAWIDTH-1:0] mlr;
    logic [CW-1:0]   cnt;
    logic            neg;
    logic [PW-1:0]   acc_sum;

`ifdef MULT_SIGNED_EN
    // Unsigned magnitude of a two's complement word; the most negative value
    // maps onto 2^(DATAWIDTH-1), which still fits in DATAWIDTH unsigned bits.
    function automatic logic [DATAWIDTH-1:0] magnitude(input logic [DATAWIDTH-1:0] x);
        return x[DATAWIDTH-1] ? (DATAWIDTH'(0) - x) : x;
    endfunction
`endif

    // Applies the result sign; negating zero yields zero, so there is no -0.
    function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] v, input logic n);
        return n ? (PW'(0) - v) : v;
    endfunction

    // Accumulator value after the current partial-product step.
    assign acc_sum = mlr[0] ? (acc + mcand) : acc;

    // Control FSM and datapath; all outputs are registered.
    always_ff @(posedge clk or negedge lowRst) begin
        if (!lowRst) begin
            state    <= IDLE;
            mcand    <= '0;
            acc      <= '0;
            mlr      <= '0;
            cnt      <= '0;
            neg      <= 1'b0;
            Product  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            lowWrOut <= 1'b1;
        end else begin
            done     <= 1'b0;
            lowWrOut <= 1'b1;
            case (state)
                IDLE: begin
                    if (!lowStart) begin
`ifdef MULT_SIGNED_EN
                        mcand <= PW'(magnitude(A));
                        mlr   <= magnitude(B);
                        neg   <= A[DATAWIDTH-1] ^ B[DATAWIDTH-1];
`else
                        mcand <= PW'(A);
                        mlr   <= B;
                        neg   <= 1'b0;
`endif
                        acc   <= '0;
                        cnt   <= CW'(DATAWIDTH);
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc   <= acc_sum;
                    mcand <= mcand << 1;
                    mlr   <= mlr >> 1;
                    cnt   <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        Product  <= apply_sign(acc_sum, neg);
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        lowWrOut <= 1'b0;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Testbench for shift_add_multiplier (DATAWIDTH = 8): directed and random
// operations checked against an arithmetic product model and the expected
// handshake timing (busy for DATAWIDTH cycles, one done/strobe pulse).
module tb_shift_add_multiplier;

    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            lowRst;
    logic            lowStart;
    logic [DW-1:0]   A;
    logic [DW-1:0]   B;
    logic [2*DW-1:0] Product;
    logic            busy;
    logic            done;
    logic            lowWrOut;

    int n_chk  = 0;
    int n_pass = 0;

    shift_add_multiplier #(.DATAWIDTH(DW)) dut (
        .clk      (clk),
        .lowRst   (lowRst),
        .lowStart (lowStart),
        .A        (A),
        .B        (B),
        .Product  (Product),
        .busy     (busy),
        .done     (done),
        .lowWrOut (lowWrOut)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    endtask

    // Reference product from plain integer arithmetic.
    function automatic logic [2*DW-1:0] model(input logic [DW-1:0] a, input logic [DW-1:0] b);
        int pa;
        int pb;
`ifdef MULT_SIGNED_EN
        pa = int'($signed(a));
        pb = int'($signed(b));
`else
        pa = int'(a);
        pb = int'(b);
`endif
        return (2*DW)'(pa * pb);
    endfunction

    // One operation: start pulse, optional ignored start pulse at sample
    // index pulse_at (-1 for none), optional operand scrambling mid-flight.
    task automatic run_op(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input int pulse_at, input bit scramble);
        logic [2*DW-1:0] exp;
        logic [2*DW-1:0] prod_at_done;
        int busy_n;
        int done_n;
        int done_at;
        int wr_bad;
        exp = model(a, b);
        busy_n = 0; done_n = 0; done_at = -1; wr_bad = 0; prod_at_done = '0;
        @(negedge clk);
        A = a; B = b; lowStart = 1'b0;
        @(negedge clk);
        lowStart = 1'b1;
        for (int i = 0; i <= DW + 2; i++) begin
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                done_at = i;
                prod_at_done = Product;
            end
            if (lowWrOut !== ~done) wr_bad++;
            lowStart = (i == pulse_at) ? 1'b0 : 1'b1;
            if (scramble) begin
                A = DW'($urandom);
                B = DW'($urandom);
            end
            @(negedge clk);
        end
        lowStart = 1'b1;
        chk({tag, "_busy_cycles"}, busy_n, DW);
        chk({tag, "_done_count"}, done_n, 1);
        chk({tag, "_done_latency"}, done_at, DW);
        chk({tag, "_wr_strobe"}, wr_bad, 0);
        chk({tag, "_product"}, prod_at_done, exp);
        chk({tag, "_product_hold"}, Product, exp);
    endtask

    initial begin
        int last_done;
        int pulses;
        int bad_gap;
        int stray;
        logic [DW-1:0] ra;
        logic [DW-1:0] rb;

        lowRst = 1'b0; lowStart = 1'b1; A = '0; B = '0;
        repeat (3) @(negedge clk);
        chk("rst_product", Product, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_lowwr", lowWrOut, 1);
        lowRst = 1'b1;
        @(negedge clk);

        run_op("a13b11", 8'd13, 8'd11, -1, 1'b0);
        run_op("a255b255", 8'd255, 8'd255, -1, 1'b0);
        run_op("a0b200", 8'd0, 8'd200, -1, 1'b0);
        run_op("ignore_start", 8'd27, 8'd9, 2, 1'b1);
        run_op("ignore_in_done", 8'd100, 8'd3, DW, 1'b0);
        run_op("afd_b05", 8'hFD, 8'h05, -1, 1'b0);
        run_op("a80b80", 8'h80, 8'h80, -1, 1'b0);
        run_op("a80b01", 8'h80, 8'h01, -1, 1'b0);

        // Held-low start retriggers with a fixed period.
        @(negedge clk);
        A = 8'd3; B = 8'd4; lowStart = 1'b0;
        last_done = -1; pulses = 0; bad_gap = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                chk("held_product", Product, model(8'd3, 8'd4));
                if (last_done < 0) chk("held_first_latency", i, DW);
                else if (i - last_done != DW + 2) bad_gap++;
                last_done = i;
            end
        end
        lowStart = 1'b1;
        chk("held_pulses", pulses, 4);
        chk("held_period", bad_gap, 0);
        repeat (DW + 4) @(negedge clk);

        // Reset mid-operation aborts without a strobe.
        A = 8'd13; B = 8'd11; lowStart = 1'b0;
        @(negedge clk);
        lowStart = 1'b1;
        repeat (3) @(negedge clk);
        lowRst = 1'b0;
        #1;
        chk("midrst_product", Product, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_lowwr", lowWrOut, 1);
        @(negedge clk);
        lowRst = 1'b1;
        stray = 0;
        for (int i = 0; i < DW + 4; i++) begin
            @(negedge clk);
            if (done || !lowWrOut || busy) stray++;
        end
        chk("midrst_no_activity", stray, 0);
        run_op("after_rst", 8'd13, 8'd11, -1, 1'b0);

        for (int n = 0; n < 24; n++) begin
            ra = DW'($urandom);
            rb = DW'($urandom);
            run_op("rand", ra, rb, (n % 3 == 0) ? int'($urandom_range(0, DW)) : -1, n[0]);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
